dispatch_lane_splitter: RTL and testbench
=========================================

Name: dispatch_lane_splitter

Overview:
- Sits directly downstream of the per-execution-unit dispatch buffers, at the front of an execution unit.
- Accepts one full-warp instruction packet (NUM_THREADS lanes of operands) through a valid/ready handshake.
- Re-issues that packet as ceil(NUM_THREADS/NUM_LANES) narrower packets of NUM_LANES lanes each, so units with fewer physical lanes than threads process a warp over several cycles.
- Each output packet is tagged with a packet id (pid) plus start-of-packet and end-of-packet markers.

Parameters:
NUM_THREADS, 4, threads per warp; power of two.
NUM_LANES, 2, lanes per output packet; power of two, divides NUM_THREADS, <= NUM_THREADS.
XLEN, 32, operand width.
UUID_W, 44, instruction uuid width.
WID_W, 2, issue-warp index width.
PC_W, 30, PC width.
OP_W, 4, op_type width.
ARGS_W, 16, op_args width.
NR_W, 6, destination register index width.
Derived: BATCHES = NUM_THREADS/NUM_LANES; PID_W = max(1, clog2(BATCHES)); NT_W = max(1, clog2(NUM_THREADS)).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input packet valid
in_ready  out  1  input packet accepted when in_valid && in_ready
in_uuid  in  UUID_W  instruction uuid
in_wid  in  WID_W  issue-warp index
in_tmask  in  NUM_THREADS  thread mask
in_pc  in  PC_W  PC
in_op_type  in  OP_W  op type
in_op_args  in  ARGS_W  op args
in_wb  in  1  writeback enable
in_rd  in  NR_W  destination register
in_tid  in  NT_W  last active thread id
in_rs1_data, in_rs2_data, in_rs3_data  in  NUM_THREADS*XLEN each  operands; lane i at bits [i*XLEN +: XLEN]
out_valid  out  1  output packet valid
out_ready  in  1  downstream accepts
out_uuid, out_wid, out_pc, out_op_type, out_op_args, out_wb, out_rd, out_tid  out  same widths  held copies of input fields
out_tmask  out  NUM_LANES  tmask slice for current pid
out_rs1_data, out_rs2_data, out_rs3_data  out  NUM_LANES*XLEN each  operand slices for current pid
out_pid  out  PID_W  batch index of current packet
out_sop  out  1  first packet of instruction
out_eop  out  1  last packet of instruction

Behaviour:
- Reset is asynchronous and active-high, on clk. Reset drives out_valid=0, busy=0, pid=0. in_ready=1 in the cycle after reset deasserts. Held data registers are not reset; outputs other than out_valid are don't-care while out_valid=0.
- State: busy flag, held input copy, pid counter. out_valid = busy.
- Slicing: out_tmask = held_tmask[pid*NUM_LANES +: NUM_LANES]. Operand slices use the same lane range. Slices are taken combinationally from the held copy using the registered pid.
- last = (pid == last batch index). Last batch index is BATCHES-1, or the last non-empty batch when the optional feature is on.
- in_ready = ~busy || (out_ready && last). This gives back-to-back operation with no bubble.
- Input fire: capture all fields, set busy=1, pid=first batch. Latency is 1 cycle from input fire to out_valid.
- Output fire (out_valid && out_ready):
  - not last: pid advances to the next batch; busy stays 1.
  - last with simultaneous input fire: load the new packet and reset pid.
  - last without input fire: busy=0, pid=0.
- out_sop = (pid == first batch). out_eop = last. When BATCHES==1: sop=eop=1, pid=0, and one packet per cycle sustained.
- Stall: with out_valid=1 and out_ready=0, all outputs hold stable and in_ready=0 (when busy).
- Reset mid-sequence: remaining batches are discarded, and the next accepted packet starts at pid=0.
- No output field depends combinationally on in_* signals.

Optional Feature:
DISPATCH_SKIP_EMPTY_EN
- Defined:
  - Batches whose tmask slice is all-zero are never issued.
  - First batch = lowest non-empty index. Next pid = next higher non-empty index. Last = highest non-empty index.
  - An all-zero in_tmask issues exactly one packet: pid=0, sop=eop=1, out_tmask=0.
- Undefined: all BATCHES packets are issued in order 0..BATCHES-1, including packets with zero tmask.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> out_valid=0 immediately; after release, in_ready=1, out_valid=0.
- Basic split: NUM_THREADS=4, NUM_LANES=2, in_tmask=4'b1111, rs1 lanes {3,2,1,0}={D,C,B,A}, out_ready=1 -> two packets on consecutive cycles:
  - pid0: tmask 2'b11, rs1 {B,A}, sop=1, eop=0.
  - pid1: tmask 2'b11, rs1 {D,C}, sop=0, eop=1.
  - in_ready=1 during pid1.
- Back-to-back: two input packets offered continuously, out_ready=1 -> 4 output packets in 4 consecutive cycles, no bubble; second uuid appears the cycle after the first eop.
- Backpressure: out_ready=0 for 3 cycles at pid0 -> outputs stable, pid stays 0, in_ready=0; release -> pid1 follows next cycle.
- Sparse mask, in_tmask=4'b1100:
  - Feature off: pid0 (tmask 00, sop=1), then pid1 (tmask 11, eop=1).
  - Feature on: single pid1 packet with sop=eop=1.
  - in_tmask=0 with feature on: single pid0 packet, sop=eop=1.
- NUM_LANES=NUM_THREADS=4: 5 consecutive inputs -> 5 outputs in 5 cycles, pid=0, sop=eop=1 each.

Source files
------------

// File: rtl/dispatch_lane_splitter_if.sv
// Handshake bundle for dispatch_lane_splitter: full-warp packet in, lane-sliced packets out.
interface dispatch_lane_splitter_if #(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned NUM_LANES   = 2,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned UUID_W      = 44,
  parameter int unsigned WID_W       = 2,
  parameter int unsigned PC_W        = 30,
  parameter int unsigned OP_W        = 4,
  parameter int unsigned ARGS_W      = 16,
  parameter int unsigned NR_W        = 6
);
  localparam int unsigned BATCHES = NUM_THREADS / NUM_LANES;
  localparam int unsigned PID_W   = (BATCHES > 1) ? $clog2(BATCHES) : 1;
  localparam int unsigned NT_W    = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  logic                        in_valid;
  logic                        in_ready;
  logic [UUID_W-1:0]           in_uuid;
  logic [WID_W-1:0]            in_wid;
  logic [NUM_THREADS-1:0]      in_tmask;
  logic [PC_W-1:0]             in_pc;
  logic [OP_W-1:0]             in_op_type;
  logic [ARGS_W-1:0]           in_op_args;
  logic                        in_wb;
  logic [NR_W-1:0]             in_rd;
  logic [NT_W-1:0]             in_tid;
  logic [NUM_THREADS*XLEN-1:0] in_rs1_data;
  logic [NUM_THREADS*XLEN-1:0] in_rs2_data;
  logic [NUM_THREADS*XLEN-1:0] in_rs3_data;

  logic                        out_valid;
  logic                        out_ready;
  logic [UUID_W-1:0]           out_uuid;
  logic [WID_W-1:0]            out_wid;
  logic [NUM_LANES-1:0]        out_tmask;
  logic [PC_W-1:0]             out_pc;
  logic [OP_W-1:0]             out_op_type;
  logic [ARGS_W-1:0]           out_op_args;
  logic                        out_wb;
  logic [NR_W-1:0]             out_rd;
  logic [NT_W-1:0]             out_tid;
  logic [NUM_LANES*XLEN-1:0]   out_rs1_data;
  logic [NUM_LANES*XLEN-1:0]   out_rs2_data;
  logic [NUM_LANES*XLEN-1:0]   out_rs3_data;
  logic [PID_W-1:0]            out_pid;
  logic                        out_sop;
  logic                        out_eop;

  modport master (
    output in_valid, in_uuid, in_wid, in_tmask, in_pc, in_op_type, in_op_args, in_wb, in_rd,
           in_tid, in_rs1_data, in_rs2_data, in_rs3_data, out_ready,
    input  in_ready, out_valid, out_uuid, out_wid, out_tmask, out_pc, out_op_type, out_op_args,
           out_wb, out_rd, out_tid, out_rs1_data, out_rs2_data, out_rs3_data, out_pid, out_sop,
           out_eop
  );

  modport slave (
    input  in_valid, in_uuid, in_wid, in_tmask, in_pc, in_op_type, in_op_args, in_wb, in_rd,
           in_tid, in_rs1_data, in_rs2_data, in_rs3_data, out_ready,
    output in_ready, out_valid, out_uuid, out_wid, out_tmask, out_pc, out_op_type, out_op_args,
           out_wb, out_rd, out_tid, out_rs1_data, out_rs2_data, out_rs3_data, out_pid, out_sop,
           out_eop
  );
endinterface

// File: rtl/dispatch_lane_splitter.sv
// Splits a full-warp dispatch packet into NUM_LANES-wide batches tagged with pid/sop/eop.
// Optional: define DISPATCH_SKIP_EMPTY_EN to skip batches whose tmask slice is all zero.
module dispatch_lane_splitter #(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned NUM_LANES   = 2,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned UUID_W      = 44,
  parameter int unsigned WID_W       = 2,
  parameter int unsigned PC_W        = 30,
  parameter int unsigned OP_W        = 4,
  parameter int unsigned ARGS_W      = 16,
  parameter int unsigned NR_W        = 6
) (
  input logic                    clk,
  input logic                    reset,
  dispatch_lane_splitter_if.slave io
);
  localparam int unsigned BATCHES = NUM_THREADS / NUM_LANES;
  localparam int unsigned PID_W   = (BATCHES > 1) ? $clog2(BATCHES) : 1;
  localparam int unsigned NT_W    = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  typedef struct packed {
    logic [UUID_W-1:0]           uuid;
    logic [WID_W-1:0]            wid;
    logic [NUM_THREADS-1:0]      tmask;
    logic [PC_W-1:0]             pc;
    logic [OP_W-1:0]             op_type;
    logic [ARGS_W-1:0]           op_args;
    logic                        wb;
    logic [NR_W-1:0]             rd;
    logic [NT_W-1:0]             tid;
    logic [NUM_THREADS*XLEN-1:0] rs1;
    logic [NUM_THREADS*XLEN-1:0] rs2;
    logic [NUM_THREADS*XLEN-1:0] rs3;
  } hold_t;

  hold_t            hold_d, hold_q;
  logic             busy_d, busy_q;
  logic [PID_W-1:0] pid_d, pid_q;
  logic [PID_W-1:0] in_first, first_pid, last_pid, next_pid;
  logic             last, in_fire, out_fire;

`ifdef DISPATCH_SKIP_EMPTY_EN
  function automatic logic [BATCHES-1:0] batch_nz(input logic [NUM_THREADS-1:0] m);
    logic [BATCHES-1:0] nz;
    for (int b = 0; b < BATCHES; b++) nz[b] = |m[b*NUM_LANES +: NUM_LANES];
    return nz;
  endfunction

  logic [BATCHES-1:0] nz_in, nz_q;

  // Empty masks collapse to a single pid 0 packet since every scan defaults to 0.
  always_comb begin
    nz_in     = batch_nz(io.in_tmask);
    nz_q      = batch_nz(hold_q.tmask);
    in_first  = '0;
    first_pid = '0;
    last_pid  = '0;
    next_pid  = '0;
    for (int b = BATCHES - 1; b >= 0; b--) begin
      if (nz_in[b]) in_first = PID_W'(b);
      if (nz_q[b]) first_pid = PID_W'(b);
      if (nz_q[b] && (PID_W'(b) > pid_q)) next_pid = PID_W'(b);
    end
    for (int b = 0; b < BATCHES; b++) begin
      if (nz_q[b]) last_pid = PID_W'(b);
    end
  end
`else
  assign in_first  = '0;
  assign first_pid = '0;
  assign last_pid  = PID_W'(BATCHES - 1);
  assign next_pid  = pid_q + PID_W'(1);
`endif

  assign last     = (pid_q == last_pid);
  assign out_fire = busy_q & io.out_ready;
  assign in_fire  = io.in_valid & io.in_ready;

  always_comb begin
    io.in_ready    = ~busy_q | (io.out_ready & last);
    io.out_valid   = busy_q;
    io.out_uuid    = hold_q.uuid;
    io.out_wid     = hold_q.wid;
    io.out_pc      = hold_q.pc;
    io.out_op_type = hold_q.op_type;
    io.out_op_args = hold_q.op_args;
    io.out_wb      = hold_q.wb;
    io.out_rd      = hold_q.rd;
    io.out_tid     = hold_q.tid;
    io.out_pid     = pid_q;
    io.out_sop     = (pid_q == first_pid);
    io.out_eop     = last;
  end

  always_comb begin
    io.out_tmask    = '0;
    io.out_rs1_data = '0;
    io.out_rs2_data = '0;
    io.out_rs3_data = '0;
    for (int b = 0; b < BATCHES; b++) begin
      if (pid_q == PID_W'(b)) begin
        io.out_tmask    = hold_q.tmask[b*NUM_LANES +: NUM_LANES];
        io.out_rs1_data = hold_q.rs1[b*NUM_LANES*XLEN +: NUM_LANES*XLEN];
        io.out_rs2_data = hold_q.rs2[b*NUM_LANES*XLEN +: NUM_LANES*XLEN];
        io.out_rs3_data = hold_q.rs3[b*NUM_LANES*XLEN +: NUM_LANES*XLEN];
      end
    end
  end

  always_comb begin
    hold_d = hold_q;
    if (in_fire) begin
      hold_d.uuid    = io.in_uuid;
      hold_d.wid     = io.in_wid;
      hold_d.tmask   = io.in_tmask;
      hold_d.pc      = io.in_pc;
      hold_d.op_type = io.in_op_type;
      hold_d.op_args = io.in_op_args;
      hold_d.wb      = io.in_wb;
      hold_d.rd      = io.in_rd;
      hold_d.tid     = io.in_tid;
      hold_d.rs1     = io.in_rs1_data;
      hold_d.rs2     = io.in_rs2_data;
      hold_d.rs3     = io.in_rs3_data;
    end
  end

  // Input fire is applied last so a new packet overrides the end-of-packet clear.
  always_comb begin
    busy_d = busy_q;
    pid_d  = pid_q;
    if (out_fire) begin
      if (last) begin
        busy_d = 1'b0;
        pid_d  = '0;
      end else begin
        pid_d = next_pid;
      end
    end
    if (in_fire) begin
      busy_d = 1'b1;
      pid_d  = in_first;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      pid_q  <= '0;
    end else begin
      busy_q <= busy_d;
      pid_q  <= pid_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end
endmodule

// File: tb/tb_dispatch_lane_splitter.sv
// Scoreboard bench for dispatch_lane_splitter: a 4-thread/2-lane and a 4-thread/4-lane instance.
module tb_dispatch_lane_splitter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dispatch_lane_splitter_if #(.NUM_THREADS(4), .NUM_LANES(2)) bus_a ();
  dispatch_lane_splitter_if #(.NUM_THREADS(4), .NUM_LANES(4)) bus_b ();

  dispatch_lane_splitter #(.NUM_THREADS(4), .NUM_LANES(2)) dut_a (
    .clk(clk), .reset(reset), .io(bus_a)
  );
  dispatch_lane_splitter #(.NUM_THREADS(4), .NUM_LANES(4)) dut_b (
    .clk(clk), .reset(reset), .io(bus_b)
  );

  typedef struct {
    logic [43:0]  uuid;
    logic         pid;
    logic         sop;
    logic         eop;
    logic [3:0]   tmask;
    logic [127:0] rs1;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   fire_a[$];
  int   fire_b[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t ea, eb;

  localparam logic [127:0] MASK5A = {4{32'h5A5A_5A5A}};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Side fields are a fixed scramble of the uuid so a stale or wrong capture shows up.
  function automatic logic [60:0] meta_of(input logic [43:0] u);
    return {u[1:0], u[29:0] ^ 30'h155, u[7:4], u[23:8], u[0], u[9:4], u[3:2]};
  endfunction

  function automatic bit consec(input int q[$], input int n);
    if (q.size() != n) return 1'b0;
    for (int i = 1; i < n; i++) if (q[i] != q[0] + i) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_a(input logic [43:0] u, input logic p, input logic s, input logic e,
                        input logic [1:0] tm, input logic [63:0] d);
    exp_t x;
    x.uuid = u; x.pid = p; x.sop = s; x.eop = e; x.tmask = {2'b00, tm}; x.rs1 = {64'd0, d};
    qa.push_back(x);
  endtask

  task automatic push_b(input logic [43:0] u, input logic [3:0] tm, input logic [127:0] d);
    exp_t x;
    x.uuid = u; x.pid = 1'b0; x.sop = 1'b1; x.eop = 1'b1; x.tmask = tm; x.rs1 = d;
    qb.push_back(x);
  endtask

  task automatic send_a(input logic [43:0] u, input logic [3:0] tm, input logic [127:0] d);
    int n = 0;
    bus_a.in_valid = 1'b1;
    bus_a.in_uuid = u;
    {bus_a.in_wid, bus_a.in_pc, bus_a.in_op_type, bus_a.in_op_args, bus_a.in_wb, bus_a.in_rd,
     bus_a.in_tid} = meta_of(u);
    bus_a.in_tmask = tm;
    bus_a.in_rs1_data = d;
    bus_a.in_rs2_data = ~d;
    bus_a.in_rs3_data = d ^ MASK5A;
    @(negedge clk);
    while (!bus_a.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("a_accept", 512'(bus_a.in_ready), 512'(1));
    @(posedge clk);
    #1;
    bus_a.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [43:0] u, input logic [3:0] tm, input logic [127:0] d);
    int n = 0;
    bus_b.in_valid = 1'b1;
    bus_b.in_uuid = u;
    {bus_b.in_wid, bus_b.in_pc, bus_b.in_op_type, bus_b.in_op_args, bus_b.in_wb, bus_b.in_rd,
     bus_b.in_tid} = meta_of(u);
    bus_b.in_tmask = tm;
    bus_b.in_rs1_data = d;
    bus_b.in_rs2_data = ~d;
    bus_b.in_rs3_data = d ^ MASK5A;
    @(negedge clk);
    while (!bus_b.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b_accept", 512'(bus_b.in_ready), 512'(1));
    @(posedge clk);
    #1;
    bus_b.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
    chk("drain", 512'(qa.size() + qb.size()), 512'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && bus_a.out_valid && bus_a.out_ready) begin
      if (qa.size() == 0) begin
        chk("a_extra", 512'(bus_a.out_uuid), 512'(0));
      end else begin
        ea = qa.pop_front();
        fire_a.push_back(cyc);
        chk("a_hdr", 512'({bus_a.out_uuid, bus_a.out_pid, bus_a.out_sop, bus_a.out_eop}),
            512'({ea.uuid, ea.pid, ea.sop, ea.eop}));
        chk("a_tmask", 512'(bus_a.out_tmask), 512'(ea.tmask[1:0]));
        chk("a_data", 512'({bus_a.out_rs3_data, bus_a.out_rs2_data, bus_a.out_rs1_data}),
            512'({ea.rs1[63:0] ^ MASK5A[63:0], ~ea.rs1[63:0], ea.rs1[63:0]}));
        chk("a_meta", 512'({bus_a.out_wid, bus_a.out_pc, bus_a.out_op_type, bus_a.out_op_args,
                            bus_a.out_wb, bus_a.out_rd, bus_a.out_tid}), 512'(meta_of(ea.uuid)));
        chk("a_in_ready", 512'(bus_a.in_ready), 512'(ea.eop));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && bus_b.out_valid && bus_b.out_ready) begin
      if (qb.size() == 0) begin
        chk("b_extra", 512'(bus_b.out_uuid), 512'(0));
      end else begin
        eb = qb.pop_front();
        fire_b.push_back(cyc);
        chk("b_hdr", 512'({bus_b.out_uuid, bus_b.out_pid, bus_b.out_sop, bus_b.out_eop}),
            512'({eb.uuid, eb.pid, eb.sop, eb.eop}));
        chk("b_tmask", 512'(bus_b.out_tmask), 512'(eb.tmask));
        chk("b_data", 512'({bus_b.out_rs3_data, bus_b.out_rs2_data, bus_b.out_rs1_data}),
            512'({eb.rs1 ^ MASK5A, ~eb.rs1, eb.rs1}));
        chk("b_meta", 512'({bus_b.out_wid, bus_b.out_pc, bus_b.out_op_type, bus_b.out_op_args,
                            bus_b.out_wb, bus_b.out_rd, bus_b.out_tid}), 512'(meta_of(eb.uuid)));
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus_a.in_valid = 1'b0;
    bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0;
    bus_b.out_ready = 1'b1;
    #23 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_a", 512'({bus_a.in_ready, bus_a.out_valid}), 512'(2'b10));
    chk("rst_b", 512'({bus_b.in_ready, bus_b.out_valid}), 512'(2'b10));

    // Basic split: lanes {3,2,1,0} = {D,C,B,A}.
    push_a(44'h123_4567_89A1, 1'b0, 1'b1, 1'b0, 2'b11, {32'hBBBB_0001, 32'hAAAA_0000});
    push_a(44'h123_4567_89A1, 1'b1, 1'b0, 1'b1, 2'b11, {32'hDDDD_0003, 32'hCCCC_0002});
    send_a(44'h123_4567_89A1, 4'b1111,
           {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000});
    drain();

    // Back-to-back packets must produce four beats with no bubble.
    fire_a.delete();
    push_a(44'h0F0_1234_5672, 1'b0, 1'b1, 1'b0, 2'b11, {32'h2000_0001, 32'h2000_0000});
    push_a(44'h0F0_1234_5672, 1'b1, 1'b0, 1'b1, 2'b11, {32'h2000_0003, 32'h2000_0002});
    push_a(44'hABC_DEF0_1233, 1'b0, 1'b1, 1'b0, 2'b11, {32'h3000_0001, 32'h3000_0000});
    push_a(44'hABC_DEF0_1233, 1'b1, 1'b0, 1'b1, 2'b11, {32'h3000_0003, 32'h3000_0002});
    send_a(44'h0F0_1234_5672, 4'b1111,
           {32'h2000_0003, 32'h2000_0002, 32'h2000_0001, 32'h2000_0000});
    send_a(44'hABC_DEF0_1233, 4'b1111,
           {32'h3000_0003, 32'h3000_0002, 32'h3000_0001, 32'h3000_0000});
    drain();
    chk("b2b_run", 512'(consec(fire_a, 4)), 512'(1));

    // Backpressure at pid0 for three cycles.
    bus_a.out_ready = 1'b0;
    push_a(44'h555_AAAA_F0F4, 1'b0, 1'b1, 1'b0, 2'b01, {32'h4000_0001, 32'h4000_0000});
    push_a(44'h555_AAAA_F0F4, 1'b1, 1'b0, 1'b1, 2'b10, {32'h4000_0003, 32'h4000_0002});
    send_a(44'h555_AAAA_F0F4, 4'b1001,
           {32'h4000_0003, 32'h4000_0002, 32'h4000_0001, 32'h4000_0000});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall", 512'({bus_a.out_valid, bus_a.out_pid, bus_a.in_ready, bus_a.out_uuid,
                         bus_a.out_tmask, bus_a.out_rs1_data}),
          512'({1'b1, 1'b0, 1'b0, 44'h555_AAAA_F0F4, 2'b01, 32'h4000_0001, 32'h4000_0000}));
    end
    @(posedge clk);
    #1;
    fire_a.delete();
    bus_a.out_ready = 1'b1;
    drain();
    chk("stall_release", 512'(consec(fire_a, 2)), 512'(1));

    // Sparse mask 4'b1100 and all-zero mask.
`ifdef DISPATCH_SKIP_EMPTY_EN
    push_a(44'h777_0000_1115, 1'b1, 1'b1, 1'b1, 2'b11, {32'h5000_0003, 32'h5000_0002});
    push_a(44'h888_1111_2226, 1'b0, 1'b1, 1'b1, 2'b00, {32'h6000_0001, 32'h6000_0000});
`else
    push_a(44'h777_0000_1115, 1'b0, 1'b1, 1'b0, 2'b00, {32'h5000_0001, 32'h5000_0000});
    push_a(44'h777_0000_1115, 1'b1, 1'b0, 1'b1, 2'b11, {32'h5000_0003, 32'h5000_0002});
    push_a(44'h888_1111_2226, 1'b0, 1'b1, 1'b0, 2'b00, {32'h6000_0001, 32'h6000_0000});
    push_a(44'h888_1111_2226, 1'b1, 1'b0, 1'b1, 2'b00, {32'h6000_0003, 32'h6000_0002});
`endif
    send_a(44'h777_0000_1115, 4'b1100,
           {32'h5000_0003, 32'h5000_0002, 32'h5000_0001, 32'h5000_0000});
    send_a(44'h888_1111_2226, 4'b0000,
           {32'h6000_0003, 32'h6000_0002, 32'h6000_0001, 32'h6000_0000});
    drain();

    // Asynchronous reset mid-packet discards the remaining batches.
    bus_a.out_ready = 1'b0;
    send_a(44'h999_9999_9999, 4'b1111,
           {32'h9000_0003, 32'h9000_0002, 32'h9000_0001, 32'h9000_0000});
    @(negedge clk);
    chk("pre_rst_valid", 512'(bus_a.out_valid), 512'(1));
    #2 reset = 1'b1;
    #1;
    chk("rst_async", 512'(bus_a.out_valid), 512'(0));
    @(negedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_release", 512'({bus_a.in_ready, bus_a.out_valid}), 512'(2'b10));
    bus_a.out_ready = 1'b1;
    push_a(44'hA0A_0A0A_0A0A, 1'b0, 1'b1, 1'b0, 2'b10, {32'hA000_0001, 32'hA000_0000});
    push_a(44'hA0A_0A0A_0A0A, 1'b1, 1'b0, 1'b1, 2'b11, {32'hA000_0003, 32'hA000_0002});
    send_a(44'hA0A_0A0A_0A0A, 4'b1110,
           {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000});
    drain();

    // Single-batch instance: five inputs, five outputs on consecutive cycles.
    fire_b.delete();
    for (int k = 1; k <= 5; k++) begin
      logic [43:0]  u;
      logic [127:0] d;
      logic [3:0]   tm;
      u  = 44'h210_0000_0000 + 44'(k * 17);
      d  = {32'hB000_0003 + 32'(k << 8), 32'hB000_0002 + 32'(k << 8),
            32'hB000_0001 + 32'(k << 8), 32'hB000_0000 + 32'(k << 8)};
      tm = 4'(k * 3);
      push_b(u, tm, d);
    end
    for (int k = 1; k <= 5; k++) begin
      send_b(44'h210_0000_0000 + 44'(k * 17), 4'(k * 3),
             {32'hB000_0003 + 32'(k << 8), 32'hB000_0002 + 32'(k << 8),
              32'hB000_0001 + 32'(k << 8), 32'hB000_0000 + 32'(k << 8)});
    end
    drain();
    chk("b_run", 512'(consec(fire_b, 5)), 512'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
